ex_mem_stage: RTL and testbench

//   EX/MEM pipeline register directly downstream of the ALU. Captures ALU result/zero/greater,

---
 rtl/pipe_pkg.sv | 15 +
 rtl/branch_cond.sv | 22 ++
 rtl/ex_mem_stage.sv | 151 +++++++++++++++
 tb/tb_ex_mem_stage.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch-type encodings and default datapath widths.
// Also used by the ALU control and the hazard unit.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_EQ   = 2'd1,
        BR_NE   = 2'd2,
        BR_GT   = 2'd3
    } br_type_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition resolver from ALU flags.
// Also instantiated by the ID-stage early-branch logic.
module branch_cond
    import pipe_pkg::*;
(
    input  logic [1:0] br_type_i,
    input  logic       zero_i,
    input  logic       greater_i,
    output logic       cond_o
);

    always_comb begin
        cond_o = 1'b0;
        case (br_type_i)
            BR_EQ:   cond_o = zero_i;
            BR_NE:   cond_o = ~zero_i;
            BR_GT:   cond_o = greater_i;
            default: cond_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with registered branch decision, stall/flush handling
// and retire / taken-branch statistics counters.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic              zero_i,
    input  logic              greater_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [REG_AW-1:0] rd_addr_i,
    input  logic [1:0]        br_type_i,
    input  logic [DATA_W-1:0] br_target_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              reg_write_i,
    input  logic              mem_to_reg_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] alu_result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              reg_write_o,
    output logic              mem_to_reg_o,
    output logic              br_taken_o,
    output logic [DATA_W-1:0] br_target_o,
    output logic              fwd_valid_o,
    output logic [CNT_W-1:0]  retired_cnt_o,
    output logic [CNT_W-1:0]  taken_cnt_o
);

    logic cond;

    branch_cond u_branch_cond (
        .br_type_i (br_type_i),
        .zero_i    (zero_i),
        .greater_i (greater_i),
        .cond_o    (cond)
    );

    logic              valid_q,      valid_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] store_data_q, store_data_d;
    logic [REG_AW-1:0] rd_addr_q,    rd_addr_d;
    logic              mem_read_q,   mem_read_d;
    logic              mem_write_q,  mem_write_d;
    logic              reg_write_q,  reg_write_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              br_taken_q,   br_taken_d;
    logic [DATA_W-1:0] br_target_q,  br_target_d;
    logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q,   taken_cnt_d;

    logic taken_now;
    assign taken_now = valid_i & cond;

    // Priority: flush loads a bubble, stall holds, otherwise capture EX.
    always_comb begin
        valid_d       = valid_q;
        alu_result_d  = alu_result_q;
        store_data_d  = store_data_q;
        rd_addr_d     = rd_addr_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        reg_write_d   = reg_write_q;
        mem_to_reg_d  = mem_to_reg_q;
        br_taken_d    = br_taken_q;
        br_target_d   = br_target_q;
        retired_cnt_d = retired_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        if (flush_i) begin
            valid_d      = 1'b0;
            alu_result_d = '0;
            store_data_d = '0;
            rd_addr_d    = '0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            reg_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            br_taken_d   = 1'b0;
            br_target_d  = '0;
        end else if (!stall_i) begin
            valid_d       = valid_i;
            alu_result_d  = alu_result_i;
            store_data_d  = store_data_i;
            rd_addr_d     = rd_addr_i;
            mem_read_d    = mem_read_i & valid_i;
            mem_write_d   = mem_write_i & valid_i;
            reg_write_d   = reg_write_i & valid_i;
            mem_to_reg_d  = mem_to_reg_i;
            br_taken_d    = taken_now;
            br_target_d   = br_target_i;
            retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, valid_i};
            taken_cnt_d   = taken_cnt_q + {{(CNT_W-1){1'b0}}, taken_now};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q       <= 1'b0;
            alu_result_q  <= '0;
            store_data_q  <= '0;
            rd_addr_q     <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            reg_write_q   <= 1'b0;
            mem_to_reg_q  <= 1'b0;
            br_taken_q    <= 1'b0;
            br_target_q   <= '0;
            retired_cnt_q <= '0;
            taken_cnt_q   <= '0;
        end else begin
            valid_q       <= valid_d;
            alu_result_q  <= alu_result_d;
            store_data_q  <= store_data_d;
            rd_addr_q     <= rd_addr_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            reg_write_q   <= reg_write_d;
            mem_to_reg_q  <= mem_to_reg_d;
            br_taken_q    <= br_taken_d;
            br_target_q   <= br_target_d;
            retired_cnt_q <= retired_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
        end
    end

    assign valid_o       = valid_q;
    assign alu_result_o  = alu_result_q;
    assign store_data_o  = store_data_q;
    assign rd_addr_o     = rd_addr_q;
    assign mem_read_o    = mem_read_q;
    assign mem_write_o   = mem_write_q;
    assign reg_write_o   = reg_write_q;
    assign mem_to_reg_o  = mem_to_reg_q;
    assign br_taken_o    = br_taken_q;
    assign br_target_o   = br_target_q;
    assign retired_cnt_o = retired_cnt_q;
    assign taken_cnt_o   = taken_cnt_q;
    assign fwd_valid_o   = reg_write_q & (rd_addr_q != '0);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: a default-width instance plus a CNT_W=4 instance
// sharing the same stimulus for the counter-wrap case.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid, zero, greater;
    logic        mem_read, mem_write, reg_write, mem_to_reg;
    logic [31:0] alu_result, store_data, br_target;
    logic [4:0]  rd_addr;
    logic [1:0]  br_type;

    logic        valid_o, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o;
    logic        br_taken_o, fwd_valid_o;
    logic [31:0] alu_result_o, store_data_o, br_target_o;
    logic [4:0]  rd_addr_o;
    logic [15:0] retired_cnt_o, taken_cnt_o;

    logic        w_valid_o, w_mem_read_o, w_mem_write_o, w_reg_write_o, w_mem_to_reg_o;
    logic        w_br_taken_o, w_fwd_valid_o;
    logic [31:0] w_alu_result_o, w_store_data_o, w_br_target_o;
    logic [4:0]  w_rd_addr_o;
    logic [3:0]  w_retired_cnt_o, w_taken_cnt_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .alu_result_i(alu_result), .zero_i(zero), .greater_i(greater),
        .store_data_i(store_data), .rd_addr_i(rd_addr), .br_type_i(br_type),
        .br_target_i(br_target), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .reg_write_i(reg_write), .mem_to_reg_i(mem_to_reg),
        .valid_o(valid_o), .alu_result_o(alu_result_o), .store_data_o(store_data_o),
        .rd_addr_o(rd_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .mem_to_reg_o(mem_to_reg_o), .br_taken_o(br_taken_o),
        .br_target_o(br_target_o), .fwd_valid_o(fwd_valid_o),
        .retired_cnt_o(retired_cnt_o), .taken_cnt_o(taken_cnt_o)
    );

    ex_mem_stage #(.CNT_W(4)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
        .alu_result_i(alu_result), .zero_i(zero), .greater_i(greater),
        .store_data_i(store_data), .rd_addr_i(rd_addr), .br_type_i(br_type),
        .br_target_i(br_target), .mem_read_i(mem_read), .mem_write_i(mem_write),
        .reg_write_i(reg_write), .mem_to_reg_i(mem_to_reg),
        .valid_o(w_valid_o), .alu_result_o(w_alu_result_o), .store_data_o(w_store_data_o),
        .rd_addr_o(w_rd_addr_o), .mem_read_o(w_mem_read_o), .mem_write_o(w_mem_write_o),
        .reg_write_o(w_reg_write_o), .mem_to_reg_o(w_mem_to_reg_o), .br_taken_o(w_br_taken_o),
        .br_target_o(w_br_target_o), .fwd_valid_o(w_fwd_valid_o),
        .retired_cnt_o(w_retired_cnt_o), .taken_cnt_o(w_taken_cnt_o)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; valid = 0; zero = 0; greater = 0;
        mem_read = 0; mem_write = 0; reg_write = 0; mem_to_reg = 0;
        alu_result = '0; store_data = '0; br_target = '0; rd_addr = '0; br_type = 2'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        // 1. reset with random inputs
        rst = 1; valid = 1; mem_write = 1; reg_write = 1; mem_read = 1; mem_to_reg = 1;
        alu_result = $urandom; store_data = $urandom; br_target = $urandom;
        rd_addr = 5'($urandom); br_type = 2'd1; zero = 1;
        tick(); tick();
        check_val("rst_valid",     valid_o, 0);
        check_val("rst_alu",       alu_result_o, 0);
        check_val("rst_store",     store_data_o, 0);
        check_val("rst_rd",        rd_addr_o, 0);
        check_val("rst_ctrl",      {mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o}, 0);
        check_val("rst_br",        {br_taken_o, br_target_o}, 0);
        check_val("rst_fwd",       fwd_valid_o, 0);
        check_val("rst_cnts",      {retired_cnt_o, taken_cnt_o}, 0);
        check_val("rst_wrap_cnts", {w_retired_cnt_o, w_taken_cnt_o}, 0);

        // 2. pass-through
        idle_inputs();
        valid = 1; alu_result = 32'h0000_1234; rd_addr = 5; reg_write = 1;
        tick();
        check_val("pt_alu",     alu_result_o, 32'h1234);
        check_val("pt_rd",      rd_addr_o, 5);
        check_val("pt_fwd",     fwd_valid_o, 1);
        check_val("pt_valid",   valid_o, 1);
        check_val("pt_retired", retired_cnt_o, 1);
        check_val("pt_taken",   br_taken_o, 0);

        // 3. branches
        idle_inputs();
        valid = 1; br_type = 2'd1; zero = 1; br_target = 32'h40;
        tick();
        check_val("beq_taken",  br_taken_o, 1);
        check_val("beq_target", br_target_o, 32'h40);
        check_val("beq_tcnt",   taken_cnt_o, 1);
        check_val("beq_fwd",    fwd_valid_o, 0);
        br_type = 2'd3; greater = 0; zero = 0;
        tick();
        check_val("bgt0_taken", br_taken_o, 0);
        check_val("bgt0_cnts",  {retired_cnt_o, taken_cnt_o}, {16'd3, 16'd1});
        br_type = 2'd2; zero = 0;
        tick();
        check_val("bne_taken",  br_taken_o, 1);
        check_val("bne_cnts",   {retired_cnt_o, taken_cnt_o}, {16'd4, 16'd2});
        valid = 0; br_type = 2'd3; greater = 1;
        tick();
        check_val("bgt_inv_taken", br_taken_o, 0);
        check_val("bgt_inv_cnts",  {retired_cnt_o, taken_cnt_o}, {16'd4, 16'd2});

        // 4. store plus taken branch, then stall 3 cycles, then stall+flush
        idle_inputs();
        valid = 1; mem_write = 1; alu_result = 32'h100; store_data = 32'hDEAD_BEEF;
        br_type = 2'd2; zero = 0; br_target = 32'h80;
        tick();
        check_val("st_mw",   mem_write_o, 1);
        check_val("st_data", store_data_o, 32'hDEAD_BEEF);
        check_val("st_cnts", {retired_cnt_o, taken_cnt_o}, {16'd5, 16'd3});
        stall = 1; mem_write = 0; alu_result = 32'hFFFF; store_data = 32'h0; zero = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("stall%0d_mw", i),   mem_write_o, 1);
            check_val($sformatf("stall%0d_data", i), {alu_result_o, store_data_o},
                      {32'h100, 32'hDEAD_BEEF});
            check_val($sformatf("stall%0d_br", i),   {br_taken_o, br_target_o}, {1'b1, 32'h80});
            check_val($sformatf("stall%0d_cnts", i), {retired_cnt_o, taken_cnt_o}, {16'd5, 16'd3});
        end
        flush = 1; mem_write = 1;
        tick();
        check_val("flush_mw",    mem_write_o, 0);
        check_val("flush_valid", valid_o, 0);
        check_val("flush_br",    br_taken_o, 0);
        check_val("flush_data",  {alu_result_o, store_data_o}, 0);
        check_val("flush_cnts",  {retired_cnt_o, taken_cnt_o}, {16'd5, 16'd3});

        // 5. invalid slot, rd=0 forwarding
        idle_inputs();
        valid = 0; mem_write = 1; reg_write = 1; rd_addr = 7;
        tick();
        check_val("inv_ctrl",    {mem_write_o, reg_write_o}, 0);
        check_val("inv_fwd",     fwd_valid_o, 0);
        check_val("inv_retired", retired_cnt_o, 5);
        valid = 1; mem_write = 0; rd_addr = 0; mem_to_reg = 1; mem_read = 1;
        tick();
        check_val("rd0_rw",   reg_write_o, 1);
        check_val("rd0_fwd",  fwd_valid_o, 0);
        check_val("rd0_load", {mem_read_o, mem_to_reg_o}, 2'b11);
        check_val("rd0_ret",  retired_cnt_o, 6);

        // reset mid-operation discards the in-flight instruction
        idle_inputs();
        valid = 1; mem_write = 1; reg_write = 1; rd_addr = 3;
        rst = 1;
        tick();
        check_val("midrst_ctrl", {valid_o, mem_write_o, reg_write_o, fwd_valid_o}, 0);
        check_val("midrst_cnts", {retired_cnt_o, taken_cnt_o}, 0);

        // 6. counter wrap on the CNT_W=4 instance
        idle_inputs();
        valid = 1;
        for (int i = 0; i < 17; i++) tick();
        check_val("wrap_retired", w_retired_cnt_o, 1);
        check_val("wide_retired", retired_cnt_o, 17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
